uart_frame_decoder: RTL

- Sits directly downstream of the UART receiver.
- Consumes its one-cycle byte-valid pulses and assembles fixed 6-byte command frames: SYNC, OP, ADDR, DATA_H, DATA_L, CHK.
- Checks each frame's XOR checksum and the inter-byte timeout.
- Presents each good frame as a command on a valid/ready interface to the register/control logic, and reports framing errors.

---
 rtl/uart_frame_decoder_if.sv | 26 ++
 rtl/uart_frame_decoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder_if.sv
// Byte stream in from the UART receiver; decoded command (valid/ready) and error status out.
// The decoder takes the slave modport; the byte source and command consumer take master.
interface uart_frame_decoder_if;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Cmd_Valid;
    logic        i_Cmd_Ready;
    logic [7:0]  o_Cmd_Op;
    logic [7:0]  o_Cmd_Addr;
    logic [15:0] o_Cmd_Data;
    logic        o_Frame_Err;
    logic [1:0]  o_Err_Code;
    logic [7:0]  o_Err_Count;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
        input  o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data,
               o_Frame_Err, o_Err_Code, o_Err_Count
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
        output o_Cmd_Valid, o_Cmd_Op, o_Cmd_Addr, o_Cmd_Data,
               o_Frame_Err, o_Err_Code, o_Err_Count
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/OP/ADDR/DH/DL/CHK frames into commands; o_Cmd_Valid rises one clock after the CHK byte.
// A held command waits for i_Cmd_Ready; bytes arriving meanwhile are dropped and flagged as overrun.
module uart_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 5000
) (
    input  logic                 i_Clock,
    input  logic                 reset,
    uart_frame_decoder_if.slave  bus
);
    // The counter would reach TIMEOUT_CLKS-1 on the edge where this value is seen with no byte.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 2);

    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_ADDR, S_DH, S_DL, S_CHK, S_HOLD
    } state_t;

    state_t      state, next_state;
    logic [15:0] to_cnt;
    logic [7:0]  chk_sum;
    logic [7:0]  op_q, addr_q, dh_q, dl_q;

    logic [7:0]  cmd_op, cmd_addr, err_cnt;
    logic [15:0] cmd_data;
    logic        cmd_vld, frame_err;
    logic [1:0]  err_code;

    logic        byte_vld, is_sync, in_frame, expire, xfer;
    logic        cap, clr_chk, load_cmd, err_vld;
    logic [1:0]  err_code_nxt;

    assign byte_vld = bus.i_Rx_DV;
    assign is_sync  = byte_vld && (bus.i_Rx_Byte == SYNC_BYTE);
    assign in_frame = (state == S_OP) || (state == S_ADDR) || (state == S_DH) ||
                      (state == S_DL) || (state == S_CHK);
    assign expire   = in_frame && !byte_vld && (to_cnt == TO_LAST);
    assign xfer     = cmd_vld && bus.i_Cmd_Ready;

    always_ff @(posedge i_Clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        cap          = 1'b0;
        clr_chk      = 1'b0;
        load_cmd     = 1'b0;
        err_vld      = 1'b0;
        err_code_nxt = 2'd0;
        case (state)
            S_IDLE: begin
                if (is_sync) begin
                    next_state = S_OP;
                    clr_chk    = 1'b1;
                end
            end
            S_OP, S_ADDR, S_DH, S_DL: begin
                if (byte_vld) begin
                    cap = 1'b1;
                    case (state)
                        S_OP:    next_state = S_ADDR;
                        S_ADDR:  next_state = S_DH;
                        S_DH:    next_state = S_DL;
                        default: next_state = S_CHK;
                    endcase
                end else if (expire) begin
                    err_vld      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    next_state   = S_IDLE;
                end
            end
            S_CHK: begin
                if (byte_vld) begin
                    if (bus.i_Rx_Byte == chk_sum) begin
                        load_cmd   = 1'b1;
                        next_state = S_HOLD;
                    end else begin
                        err_vld      = 1'b1;
                        err_code_nxt = ERR_CHK;
                        next_state   = S_IDLE;
                    end
                end else if (expire) begin
                    err_vld      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                    next_state   = S_IDLE;
                end
            end
            S_HOLD: begin
                // A SYNC byte landing on the handshake cycle starts the next frame at once.
                if (xfer) begin
                    if (is_sync) begin
                        next_state = S_OP;
                        clr_chk    = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end else if (byte_vld) begin
                    err_vld      = 1'b1;
                    err_code_nxt = ERR_OVERRUN;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            to_cnt    <= '0;
            chk_sum   <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            dh_q      <= '0;
            dl_q      <= '0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            err_cnt   <= '0;
        end else begin
            to_cnt <= (in_frame && !byte_vld && !expire) ? to_cnt + 16'd1 : 16'd0;

            if (clr_chk)  chk_sum <= '0;
            else if (cap) chk_sum <= chk_sum ^ bus.i_Rx_Byte;

            if (cap) begin
                case (state)
                    S_OP:    op_q   <= bus.i_Rx_Byte;
                    S_ADDR:  addr_q <= bus.i_Rx_Byte;
                    S_DH:    dh_q   <= bus.i_Rx_Byte;
                    default: dl_q   <= bus.i_Rx_Byte;
                endcase
            end

            if (load_cmd) begin
                cmd_op   <= op_q;
                cmd_addr <= addr_q;
                cmd_data <= {dh_q, dl_q};
            end

            cmd_vld   <= (next_state == S_HOLD);
            frame_err <= err_vld;
            if (err_vld) begin
                err_code <= err_code_nxt;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign bus.o_Cmd_Valid = cmd_vld;
    assign bus.o_Cmd_Op    = cmd_op;
    assign bus.o_Cmd_Addr  = cmd_addr;
    assign bus.o_Cmd_Data  = cmd_data;
    assign bus.o_Frame_Err = frame_err;
    assign bus.o_Err_Code  = err_code;
    assign bus.o_Err_Count = err_cnt;
endmodule
